hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the pipelined ARM-subset core. It replaces hard-wired E/M/W match logic with a shift-register scoreboard that tracks in-flight register writes across a configurable number of post-decode stages. From the scoreboard it produces forwarding selects, load-use stalls, PC-write stalls and flushes, plus saturating stall/flush performance counters. It sits beside the decode stage and is driven by decode-side control and E-stage branch/condition results.

## Interface
Parameters:
- NUM_SRC, 2: source operands per instruction (2..4)
- AW, 4: register tag width
- DEPTH, 3: tracked stages after D; stage 1 = E, stage DEPTH = W (3..6)
- LOAD_READY, 3: first stage at which load data can be forwarded (2..DEPTH)
- PC_TAG, 15: tag that never matches for forwarding or stalling
- CW, 32: performance counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- issue_valid_i  in  1  D holds a real instruction
- issue_wr_i  in  1  D instruction writes a register
- issue_dst_i  in  AW  D destination tag
- issue_load_i  in  1  D instruction is a load
- issue_pcwr_i  in  1  D instruction writes the PC
- issue_src_i  in  NUM_SRC*AW  D source tags, src i at [i*AW +: AW]
- issue_src_used_i  in  NUM_SRC  per-source valid
- branch_taken_i  in  1  instruction in E is a taken branch
- cond_fail_i  in  1  instruction in E fails its condition
- stall_f_o, stall_d_o, flush_d_o, flush_e_o  out  1 each  pipeline controls
- fwd_sel_o  out  NUM_SRC*FW  FW = $clog2(DEPTH+1); 0 = regfile, k = stage k
- stall_cnt_o  out  CW  cycles with stall_d_o high, saturating
- flush_cnt_o  out  CW  cycles with flush_d_o high, saturating

## Operation
- Each scoreboard entry holds: valid, wr, load, pcwr, dst, srcs, src_used.
- Every cycle, entry k+1 <= entry k for k = 1..DEPTH-1. Entry DEPTH retires.
- Entry 1 <= D fields when issue_valid_i and not flush_e_o; otherwise a bubble (valid=0).
- cond_fail_i clears wr and pcwr of entry 1 as it moves to entry 2.
- Forwarding, per E source i:
  - candidates are entries k = 2..DEPTH with valid & wr & dst==src & src_used & dst!=PC_TAG;
  - a load candidate qualifies only if k >= LOAD_READY;
  - select the lowest qualifying k, else 0.
- Load-use stall: ldr_stall when some used D source (not PC_TAG) matches a valid load entry k (k >= 1, wr set) with k+1 < LOAD_READY. It is forced 0 while branch_taken_i is high.
- pc_pending = (issue_valid_i & issue_pcwr_i) | pcwr of any valid entry 1..DEPTH-1.
- Outputs:
  - stall_f_o = ldr_stall | pc_pending
  - stall_d_o = ldr_stall
  - flush_d_o = pc_pending | entry DEPTH pcwr | branch_taken_i
  - flush_e_o = ldr_stall | branch_taken_i
- Counters increment by 1 per qualifying cycle and hold at all-ones.

## Timing
- Reset (rst_n low, asynchronous): all entries invalid, counters 0. While rst_n is low, every control output and fwd_sel_o is forced 0.
- Control and forwarding outputs are combinational from the scoreboard plus this cycle's inputs. Zero latency.
- The scoreboard updates on the rising edge of clk. Counters reflect the previous cycle's events, a 1-cycle lag.
- With defaults, a load followed by a dependent instruction costs exactly 1 stall cycle. A non-load producer costs 0 stall cycles.
- A PC write stalls F from its D cycle until it reaches W, i.e. DEPTH cycles.
- Simultaneous branch_taken_i and cond_fail_i: impossible by construction (a taken branch passed its condition). No priority is required.
- Deassertion of rst_n mid-program: the scoreboard restarts empty and no stale forwards occur.

## Structure
- Package arm_pipe_pkg holds:
  - sb_entry_t (packed struct of the entry fields);
  - the FW width function;
  - the NOP encoding constant 32'hE1A00000.
- One sub-module, sb_match: it compares one tag against all entries and returns a per-stage match vector. It is instantiated per source for both forwarding and load-use detection.

## Test plan
All scenarios use default parameters.
- Back-to-back ALU dependency: ADD dst 3, then src 3 -> fwd_sel=2 in the consumer's E cycle; one cycle later the next user of r3 gets fwd_sel=3; no stall.
- Load-use: load dst 5, next instruction uses src 5 -> stall_d_o, stall_f_o and flush_e_o high for 1 cycle, then fwd_sel=3; stall_cnt_o=1.
- Condition-failed producer: ADD dst 4 with cond_fail_i, consumer uses r4 -> fwd_sel=0.
- PC write: an instruction with issue_pcwr_i -> stall_f_o high for 3 consecutive cycles; flush_d_o also high the following cycle (entry 3 pcwr).
- Taken branch in E while D holds a load-dependent instruction -> flush_d_o=1, flush_e_o=1, stall_d_o=0.
- Tag 15 as both dst and src -> fwd_sel=0 and no stall; async reset asserted mid-sequence -> outputs 0 immediately, counters 0.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and helpers for the ARM-subset pipeline hazard logic.
// Scoreboard entries use fixed maximum widths so one struct serves every parameterisation.
package arm_pipe_pkg;

    localparam int SB_MAX_AW  = 8;
    localparam int SB_MAX_SRC = 4;

    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    typedef struct packed {
        logic                            valid;
        logic                            wr;
        logic                            load;
        logic                            pcwr;
        logic [SB_MAX_AW-1:0]            dst;
        logic [SB_MAX_SRC*SB_MAX_AW-1:0] srcs;
        logic [SB_MAX_SRC-1:0]           src_used;
    } sb_entry_t;

    function automatic int fw_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sb_match.sv
// Compares one register tag against every scoreboard entry.
// A stage matches when it holds a valid instruction that writes that tag.
module sb_match
    import arm_pipe_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DEPTH = 3
) (
    input  logic [AW-1:0]         tag,
    input  sb_entry_t [DEPTH:1]   entries,
    output logic [DEPTH:1]        match
);

    logic unused_fields;

    always_comb begin
        match = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            match[k] = entries[k].valid & entries[k].wr &
                       (entries[k].dst == SB_MAX_AW'(tag));
        end
    end

    assign unused_fields = ^entries;

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register hazard scoreboard: tracks in-flight writes after decode and derives
// forwarding selects, load-use and PC-write stalls, flushes and stall/flush counters.
module hazard_scoreboard
    import arm_pipe_pkg::*;
#(
    parameter  int NUM_SRC    = 2,
    parameter  int AW         = 4,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_READY = 3,
    parameter  int PC_TAG     = 15,
    parameter  int CW         = 32,
    localparam int FW         = fw_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic                  issue_wr_i,
    input  logic [AW-1:0]         issue_dst_i,
    input  logic                  issue_load_i,
    input  logic                  issue_pcwr_i,
    input  logic [NUM_SRC*AW-1:0] issue_src_i,
    input  logic [NUM_SRC-1:0]    issue_src_used_i,
    input  logic                  branch_taken_i,
    input  logic                  cond_fail_i,
    output logic                  stall_f_o,
    output logic                  stall_d_o,
    output logic                  flush_d_o,
    output logic                  flush_e_o,
    output logic [NUM_SRC*FW-1:0] fwd_sel_o,
    output logic [CW-1:0]         stall_cnt_o,
    output logic [CW-1:0]         flush_cnt_o
);

    sb_entry_t [DEPTH:1]   sb_q;
    sb_entry_t [DEPTH:1]   sb_d;
    sb_entry_t             issue_entry;
    sb_entry_t             aged_entry;
    logic [AW-1:0]         e_src [NUM_SRC];
    logic [DEPTH:1]        fwd_match [NUM_SRC];
    logic [DEPTH:1]        d_match [NUM_SRC];
    logic [NUM_SRC*FW-1:0] fwd_sel;
    logic                  ldr_hit;
    logic                  ldr_stall;
    logic                  pc_pending;
    logic                  flush_d;
    logic                  flush_e;
    logic [CW-1:0]         stall_cnt;
    logic [CW-1:0]         flush_cnt;
    logic                  unused_fields;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            e_src[i] = sb_q[1].srcs[i*SB_MAX_AW +: AW];
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        sb_match #(.AW(AW), .DEPTH(DEPTH)) u_fwd_match (
            .tag     (e_src[i]),
            .entries (sb_q),
            .match   (fwd_match[i])
        );
        sb_match #(.AW(AW), .DEPTH(DEPTH)) u_ldr_match (
            .tag     (issue_src_i[i*AW +: AW]),
            .entries (sb_q),
            .match   (d_match[i])
        );
    end

    // Scanning from the oldest stage down leaves the youngest qualifying producer selected.
    always_comb begin
        fwd_sel = '0;
        ldr_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH; k >= 2; k--) begin
                if (fwd_match[i][k] && sb_q[1].src_used[i] &&
                    (e_src[i] != AW'(PC_TAG)) &&
                    (!sb_q[k].load || (k >= LOAD_READY))) begin
                    fwd_sel[i*FW +: FW] = FW'(k);
                end
            end
            for (int k = 1; k <= DEPTH; k++) begin
                if (d_match[i][k] && sb_q[k].load && issue_src_used_i[i] &&
                    (issue_src_i[i*AW +: AW] != AW'(PC_TAG)) &&
                    ((k + 1) < LOAD_READY)) begin
                    ldr_hit = 1'b1;
                end
            end
        end
        ldr_stall  = ldr_hit & ~branch_taken_i;
        pc_pending = issue_valid_i & issue_pcwr_i;
        for (int k = 1; k <= DEPTH - 1; k++) begin
            pc_pending = pc_pending | (sb_q[k].valid & sb_q[k].pcwr);
        end
        flush_d = pc_pending | (sb_q[DEPTH].valid & sb_q[DEPTH].pcwr) | branch_taken_i;
        flush_e = ldr_stall | branch_taken_i;
    end

    always_comb begin
        issue_entry = '0;
        if (issue_valid_i && !flush_e) begin
            issue_entry.valid = 1'b1;
            issue_entry.wr    = issue_wr_i;
            issue_entry.load  = issue_load_i;
            issue_entry.pcwr  = issue_pcwr_i;
            issue_entry.dst   = SB_MAX_AW'(issue_dst_i);
            for (int i = 0; i < NUM_SRC; i++) begin
                issue_entry.srcs[i*SB_MAX_AW +: SB_MAX_AW] = SB_MAX_AW'(issue_src_i[i*AW +: AW]);
            end
            issue_entry.src_used[NUM_SRC-1:0] = issue_src_used_i;
        end
        // A condition-failed instruction keeps flowing but no longer produces anything.
        aged_entry = sb_q[1];
        if (cond_fail_i) begin
            aged_entry.wr   = 1'b0;
            aged_entry.pcwr = 1'b0;
        end
        sb_d    = sb_q;
        sb_d[1] = issue_entry;
        sb_d[2] = aged_entry;
        for (int k = 3; k <= DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            sb_q <= sb_d;
            if (ldr_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_d && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // Outputs are gated by rst_n so nothing leaks out while reset is held.
    assign stall_f_o   = rst_n & (ldr_stall | pc_pending);
    assign stall_d_o   = rst_n & ldr_stall;
    assign flush_d_o   = rst_n & flush_d;
    assign flush_e_o   = rst_n & flush_e;
    assign fwd_sel_o   = rst_n ? fwd_sel : '0;
    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

    assign unused_fields = ^sb_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard with default parameters.
// Each table row is one clock cycle of decode/E inputs and the expected hazard outputs.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid_i;
    logic        issue_wr_i;
    logic [3:0]  issue_dst_i;
    logic        issue_load_i;
    logic        issue_pcwr_i;
    logic [7:0]  issue_src_i;
    logic [1:0]  issue_src_used_i;
    logic        branch_taken_i;
    logic        cond_fail_i;
    logic        stall_f_o;
    logic        stall_d_o;
    logic        flush_d_o;
    logic        flush_e_o;
    logic [3:0]  fwd_sel_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       iv, wr, ld, pc;
        logic [3:0] dst, s0, s1;
        logic [1:0] used;
        logic       br, cf;
        logic       sf, sd, fd, fe;
        logic [1:0] f0, f1;
        int         scnt, fcnt;
    } vec_t;

    vec_t vecs[$];

    hazard_scoreboard dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_valid_i    (issue_valid_i),
        .issue_wr_i       (issue_wr_i),
        .issue_dst_i      (issue_dst_i),
        .issue_load_i     (issue_load_i),
        .issue_pcwr_i     (issue_pcwr_i),
        .issue_src_i      (issue_src_i),
        .issue_src_used_i (issue_src_used_i),
        .branch_taken_i   (branch_taken_i),
        .cond_fail_i      (cond_fail_i),
        .stall_f_o        (stall_f_o),
        .stall_d_o        (stall_d_o),
        .flush_d_o        (flush_d_o),
        .flush_e_o        (flush_e_o),
        .fwd_sel_o        (fwd_sel_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int iv, wr, ld, pc, dst, s0, s1, used, br, cf,
                                input int sf, sd, fd, fe, f0, f1, scnt, fcnt);
        vec_t v;
        v.iv = 1'(iv);   v.wr = 1'(wr);   v.ld = 1'(ld);   v.pc = 1'(pc);
        v.dst = 4'(dst); v.s0 = 4'(s0);   v.s1 = 4'(s1);   v.used = 2'(used);
        v.br = 1'(br);   v.cf = 1'(cf);
        v.sf = 1'(sf);   v.sd = 1'(sd);   v.fd = 1'(fd);   v.fe = 1'(fe);
        v.f0 = 2'(f0);   v.f1 = 2'(f1);   v.scnt = scnt;   v.fcnt = fcnt;
        return v;
    endfunction

    function automatic vec_t idle(input int f0, f1, scnt, fcnt);
        return mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,f0,f1,scnt,fcnt);
    endfunction

    task automatic applyStimulus(input vec_t v);
        issue_valid_i    = v.iv;
        issue_wr_i       = v.wr;
        issue_load_i     = v.ld;
        issue_pcwr_i     = v.pc;
        issue_dst_i      = v.dst;
        issue_src_i      = {v.s1, v.s0};
        issue_src_used_i = v.used;
        branch_taken_i   = v.br;
        cond_fail_i      = v.cf;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkControls(input string tag, input int sf, sd, fd, fe, f0, f1);
        checkOutput({tag, " stall_f"}, int'(stall_f_o), sf);
        checkOutput({tag, " stall_d"}, int'(stall_d_o), sd);
        checkOutput({tag, " flush_d"}, int'(flush_d_o), fd);
        checkOutput({tag, " flush_e"}, int'(flush_e_o), fe);
        checkOutput({tag, " fwd0"},    int'(fwd_sel_o[1:0]), f0);
        checkOutput({tag, " fwd1"},    int'(fwd_sel_o[3:2]), f1);
    endtask

    initial begin
        //               iv wr ld pc dst s0 s1 us br cf | sf sd fd fe f0 f1 sc fc
        // ALU back-to-back dependency
        vecs.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 6, 3, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 7, 1, 3, 3, 0, 0,  0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(idle(0, 3, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0));
        // Load-use: one stall, then forward from W
        vecs.push_back(mk(1, 1, 1, 0, 5, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8, 5, 0, 1, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8, 5, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(3, 0, 1, 0));
        vecs.push_back(idle(0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 1, 0));
        // Condition-failed producer must not forward
        vecs.push_back(mk(1, 1, 0, 0, 4, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 9, 4, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 1, 0));
        // PC write: three F stalls, flush_d one cycle longer
        vecs.push_back(mk(1, 1, 0, 1, 15, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1, 3));
        vecs.push_back(idle(0, 0, 1, 4));
        // Taken branch overrides a pending load-use stall
        vecs.push_back(mk(1, 1, 1, 0, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 4));
        vecs.push_back(mk(1, 1, 0, 0, 10, 2, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 4));
        vecs.push_back(idle(0, 0, 1, 5));
        vecs.push_back(idle(0, 0, 1, 5));
        // Tag 15 never forwards or stalls
        vecs.push_back(mk(1, 1, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(1, 1, 0, 0, 11, 15, 15, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(idle(0, 0, 1, 5));
        vecs.push_back(mk(1, 1, 1, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(1, 1, 0, 0, 12, 15, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(idle(0, 0, 1, 5));
        vecs.push_back(idle(0, 0, 1, 5));
        // Two writers of r3 in flight: the younger one (stage 2) wins
        vecs.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(1, 1, 0, 0, 13, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(idle(2, 0, 1, 5));
        vecs.push_back(idle(0, 0, 1, 5));

        // Reset state, with inputs that would otherwise raise stall_f and flush_d
        rst_n = 1'b0;
        applyStimulus(mk(1, 1, 0, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        checkControls("reset", 0, 0, 0, 0, 0, 0);
        checkOutput("reset stall_cnt", int'(stall_cnt_o), 0);
        checkOutput("reset flush_cnt", int'(flush_cnt_o), 0);
        @(negedge clk);
        applyStimulus(idle(0, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkControls($sformatf("v%0d", i), int'(vecs[i].sf), int'(vecs[i].sd),
                          int'(vecs[i].fd), int'(vecs[i].fe), int'(vecs[i].f0), int'(vecs[i].f1));
            checkOutput($sformatf("v%0d stall_cnt", i), int'(stall_cnt_o), vecs[i].scnt);
            checkOutput($sformatf("v%0d flush_cnt", i), int'(flush_cnt_o), vecs[i].fcnt);
        end

        // Asynchronous reset while a forward and a PC-write stall are live
        @(posedge clk); #1;
        applyStimulus(mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        applyStimulus(mk(1, 1, 0, 0, 6, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        applyStimulus(mk(1, 1, 0, 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkControls("pre-reset", 1, 0, 1, 0, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkControls("mid-reset", 0, 0, 0, 0, 0, 0);
        checkOutput("mid-reset stall_cnt", int'(stall_cnt_o), 0);
        checkOutput("mid-reset flush_cnt", int'(flush_cnt_o), 0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(mk(1, 1, 0, 0, 14, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        #1;
        checkControls("post-reset D", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        applyStimulus(idle(0, 0, 0, 0));
        @(negedge clk);
        checkControls("post-reset E", 0, 0, 0, 0, 0, 0);
        checkOutput("post-reset stall_cnt", int'(stall_cnt_o), 0);
        checkOutput("post-reset flush_cnt", int'(flush_cnt_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
